demux_1_8_16: RTL
=================

# demux_1_8_16

Registered 16-bit 1-to-8 demultiplexer and frame collector, the write-side counterpart of the 16-bit 8:1 word multiplexer. Accepts one 16-bit word per handshake and steers it into one of eight output holding registers, chosen either by the select lines or by an internal auto-increment pointer. Once all eight slots are filled, it presents a complete frame and stalls input until the frame is acknowledged. It feeds the 8:1 mux bank, which then reads the frame back out word by word.

## Interface
- WIDTH, 16, data width of input word and of each output slot
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  data word to store
- s2, s1, s0  input  1 each  slot select, s2 is MSB; used only when auto=0
- auto  input  1  1: slot = internal pointer; 0: slot = {s2,s1,s0}
- in_valid  input  1  word on `in` is valid
- in_ready  output  1  block can accept a word
- o0 … o7  output  WIDTH each  slot holding registers
- loaded  output  8  bit k set when slot k has been written in the current frame
- out_valid  output  1  complete frame present on o0..o7
- out_ack  input  1  consumer has taken the frame

## Operation
- States: FILL, HOLD. Reset state is FILL.
- Accept event = in_valid & in_ready, evaluated on the rising edge of clk.
- FILL:
  - in_ready=1, out_valid=0.
  - On accept: o[idx] <= in and loaded[idx] <= 1, where idx = auto ? ptr : {s2,s1,s0}.
  - In auto mode, an accept advances ptr by 1 modulo 8 (7 wraps to 0). ptr does not move on accepts made with auto=0.
  - Writing a slot that is already loaded overwrites its data. loaded is unchanged.
  - When an accept makes loaded equal to 8'hFF, the next state is HOLD.
- HOLD:
  - in_ready=0 and out_valid=1. in_valid is ignored.
  - o0..o7 are stable.
  - On out_ack=1: clear loaded to 0, set ptr to 0, next state FILL.
- out_ack is ignored in FILL.
- Mixing auto and addressed writes within one frame is legal. The frame completes only when all eight loaded bits are set.
- Arithmetic: ptr is 3 bits and wraps naturally. No width conversion; `in` is stored verbatim.

## Timing
- Reset values (asynchronous, effective immediately while rst_n=0):
  - o0..o7 = 0, loaded = 0, ptr = 0
  - out_valid = 0, in_ready = 1 after reset is released
- Write latency: a word accepted at edge N appears on o[idx] and loaded[idx] after edge N.
- Frame completion: if the eighth distinct slot is accepted at edge N, then after edge N out_valid=1 and in_ready=0. No bubble is inserted.
- Acknowledge: out_ack=1 sampled at edge M in HOLD gives out_valid=0, in_ready=1, loaded=0 after edge M. The first word of the next frame can be accepted at edge M+1.
- Handshake: in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ack. Both are registered state decodes.
- Reset mid-frame or mid-HOLD: all partial data and state are discarded and the block returns to FILL.
- in_valid=1 during HOLD: no write and no state change; the word must be re-presented after the ack.

## Configuration
- DEMUX_1_8_16_CLEAR_ON_ACK_EN
  - Defined: on an ack in HOLD, o0..o7 are also cleared to 0 on the same edge as loaded.
  - Undefined: o0..o7 keep the last frame's data until each slot is overwritten.
- Handshake and timing are identical in both builds.

## Test plan
- Reset: rst_n=0 mid-stream → o0..o7=0, loaded=0, out_valid=0, and in_ready=1 after release.
- Auto fill: auto=1, in_valid=1 for 8 cycles with in=10,22,2,12,233,32,23,231 → o0..o7 equal those values in order, out_valid=1 the cycle after the 8th accept, in_ready=0.
- Addressed fill with overwrite:
  - Stimulus: auto=0, write slot 3=100, then slot 3=200, then the other seven slots.
  - Response: o3=200, out_valid is set only after the 8th distinct slot is written, loaded=8'hFF.
- Stall and ack: in HOLD hold in_valid=1 with in=16'hBEEF for 5 cycles, then pulse out_ack for one cycle.
  - No slot changes during the stall.
  - The cycle after the ack: in_ready=1, loaded=0, and the next accept writes slot 0 in auto mode.
- Wrap-around: two back-to-back auto frames with an ack between them → the second frame starts at o0.
  - Macro defined: o1..o7 read 0 right after the ack.
  - Macro undefined: o1..o7 read the first frame's values right after the ack.
- Reset during HOLD: assert rst_n=0 while out_valid=1 → out_valid drops immediately without waiting for a clock, and all outputs read 0.

Source files
------------

// File: rtl/demux_1_8_16_if.sv
// Word-in / frame-out bus of the 1:8 demux frame collector.
// master = producer/consumer side, slave = the demux itself.
interface demux_1_8_16_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] in;
    logic             s2, s1, s0;
    logic             auto;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]       loaded;
    logic             out_valid;
    logic             out_ack;

    modport master (
        output in, s2, s1, s0, auto, in_valid, out_ack,
        input  in_ready, o0, o1, o2, o3, o4, o5, o6, o7, loaded, out_valid
    );

    modport slave (
        input  in, s2, s1, s0, auto, in_valid, out_ack,
        output in_ready, o0, o1, o2, o3, o4, o5, o6, o7, loaded, out_valid
    );
endinterface

// File: rtl/demux_1_8_16.sv
// Registered 1:8 demux that collects eight words into a frame and stalls until acked.
// Optional DEMUX_1_8_16_CLEAR_ON_ACK_EN: zero all slots on the ack edge.
module demux_1_8_16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1_8_16_if.slave        bus
);
    localparam int NUM_SLOTS = 8;

    typedef enum logic {FILL, HOLD} state_t;

    typedef struct packed {
        logic             vld;
        logic [2:0]       idx;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    state_t                             state, state_nxt;
    logic [2:0]                         ptr, ptr_nxt;
    logic [NUM_SLOTS-1:0]               loaded_q, loaded_nxt, wr_en;
    logic [NUM_SLOTS-1:0][WIDTH-1:0]    slot_q;
    wr_req_t                            req;
    logic                               ack, clr;

    assign req.vld  = bus.in_valid & (state == FILL);
    assign req.idx  = bus.auto ? ptr : {bus.s2, bus.s1, bus.s0};
    assign req.data = bus.in;
    assign ack      = (state == HOLD) & bus.out_ack;

`ifdef DEMUX_1_8_16_CLEAR_ON_ACK_EN
    assign clr = ack;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        wr_en = '0;
        if (req.vld) wr_en[req.idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            ptr      <= '0;
            loaded_q <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            loaded_q <= loaded_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        loaded_nxt = loaded_q;
        case (state)
            FILL: begin
                if (req.vld) begin
                    loaded_nxt = loaded_q | wr_en;
                    if (bus.auto) ptr_nxt = ptr + 3'd1;
                    // Go to HOLD on the same edge the last slot lands: no bubble.
                    if (&loaded_nxt) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    loaded_nxt = '0;
                    ptr_nxt    = '0;
                    state_nxt  = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic [WIDTH-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        q <= '0;
            else if (clr)      q <= '0;
            else if (wr_en[g]) q <= req.data;
        end
        assign slot_q[g] = q;
    end

    assign bus.o0        = slot_q[0];
    assign bus.o1        = slot_q[1];
    assign bus.o2        = slot_q[2];
    assign bus.o3        = slot_q[3];
    assign bus.o4        = slot_q[4];
    assign bus.o5        = slot_q[5];
    assign bus.o6        = slot_q[6];
    assign bus.o7        = slot_q[7];
    assign bus.loaded    = loaded_q;
    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == HOLD);
endmodule
